qmult_seq: RTL and testbench

QMULT_SEQ -- requirements
Module: qmult_seq

---
 rtl/qmult_seq.sv | 150 +++++++++++++++
 tb/tb_qmult_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/qmult_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : qmult_seq                                                       |
// | Brief    : Sequential signed Qm.n fixed-point multiplier (shift-add,       |
// |            one multiplier bit per cycle) with rounding and saturation.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module qmult_seq #(
  parameter int N     = 16,
  parameter int Q     = 10,
  parameter int ROUND = 1,
  parameter int SAT   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         overflow
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  // One extra bit so the rounding increment can never wrap the scaled magnitude.
  localparam int MW = 2*N - Q + 1;

  localparam logic [MW-1:0] C_MAX_POS = MW'((64'd1 << (N-1)) - 64'd1);
  localparam logic [MW-1:0] C_MAX_NEG = MW'(64'd1 << (N-1));
  localparam logic [N-1:0]  C_SAT_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]  C_SAT_NEG = {1'b1, {(N-1){1'b0}}};
  localparam logic [CW-1:0] C_LAST    = CW'(N-1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [2*N-1:0] r_acc;
  logic [2*N-1:0] r_mcand;
  logic [N-1:0]   r_mplier;
  logic           r_sign;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_result;
  logic           r_overflow;

  logic [N-1:0]   w_mag_a;
  logic [N-1:0]   w_mag_b;
  logic [2*N-1:0] w_acc_next;
  logic           w_rnd;
  logic [MW-1:0]  w_mag_m;
  logic           w_ovf;
  logic [N-1:0]   w_wrap;
  logic [N-1:0]   w_res;
  logic           w_last;

  // Unsigned magnitudes: the most negative value maps to 2^(N-1) without loss.
  assign w_mag_a = a[N-1] ? (~a + {{(N-1){1'b0}}, 1'b1}) : a;
  assign w_mag_b = b[N-1] ? (~b + {{(N-1){1'b0}}, 1'b1}) : b;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_last     = (r_cnt == C_LAST);

  assign w_rnd   = (ROUND != 0) ? w_acc_next[Q-1] : 1'b0;
  assign w_mag_m = {1'b0, w_acc_next[2*N-1:Q]} + {{(MW-1){1'b0}}, w_rnd};
  assign w_ovf   = r_sign ? (w_mag_m > C_MAX_NEG) : (w_mag_m > C_MAX_POS);
  assign w_wrap  = r_sign ? (-w_mag_m[N-1:0]) : w_mag_m[N-1:0];

  always_comb begin
    w_res = w_wrap;
    if (w_mag_m == '0) begin
      w_res = '0;
    end else if (w_ovf && (SAT != 0)) begin
      w_res = r_sign ? C_SAT_NEG : C_SAT_POS;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = CALC;
      end
      CALC: begin
        if (w_last) w_state_next = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_sign     <= 1'b0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_acc    <= '0;
            r_mcand  <= {{N{1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_sign   <= a[N-1] ^ b[N-1];
            r_cnt    <= '0;
          end
        end
        CALC: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          if (w_last) begin
            r_result   <= w_res;
            r_overflow <= w_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign result   = r_result;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_qmult_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_qmult_seq                                                    |
// | Brief    : Scoreboard bench for qmult_seq (round+saturate and              |
// |            truncate+wrap instances driven in parallel).                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_qmult_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        in_ready,  alt_in_ready;
  logic        out_valid, alt_out_valid;
  logic [15:0] result,    alt_result;
  logic        overflow,  alt_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [16:0] exp_main[$];
  logic [16:0] exp_alt[$];

  qmult_seq #(.N(16), .Q(10), .ROUND(1), .SAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow)
  );

  qmult_seq #(.N(16), .Q(10), .ROUND(0), .SAT(0)) dut_alt (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(alt_in_ready),
    .a(a), .b(b), .out_valid(alt_out_valid), .out_ready(out_ready),
    .result(alt_result), .overflow(alt_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact signed product, then scale/round/saturate as arithmetic.
  function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input int rnd, input int sat);
    longint p, mag, m, v;
    logic   s, ovf;
    logic [15:0] res;
    p   = longint'($signed(x)) * longint'($signed(y));
    mag = (p < 0) ? -p : p;
    s   = x[15] ^ y[15];
    m   = (mag >> 10) + ((rnd != 0) ? ((mag >> 9) & 64'd1) : 64'd0);
    ovf = s ? (m > 32768) : (m > 32767);
    v   = s ? -m : m;
    res = v[15:0];
    if (ovf && (sat != 0)) res = s ? 16'h8000 : 16'h7FFF;
    if (m == 0) res = 16'h0000;
    return {ovf, res};
  endfunction

  task automatic compare_outputs(input logic [16:0] em, input logic [16:0] ea);
    check("result",       {16'h0, result},           {16'h0, em[15:0]});
    check("overflow",     {31'h0, overflow},         {31'h0, em[16]});
    check("alt_result",   {16'h0, alt_result},       {16'h0, ea[15:0]});
    check("alt_overflow", {31'h0, alt_overflow},     {31'h0, ea[16]});
    check("alt_valid",    {31'h0, alt_out_valid},    32'd1);
  endtask

  // Drive one operation; hold the result for 'stall' cycles before consuming it.
  task automatic do_op(input logic [15:0] x, input logic [15:0] y, input int stall);
    int lat;
    logic [16:0] em, ea;
    check("in_ready", {31'h0, in_ready}, 32'd1);
    a = x; b = y; in_valid = 1'b1; out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_main.push_back(model(x, y, 1, 1));
    exp_alt.push_back(model(x, y, 0, 0));
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'd16);
    if (out_valid) begin
      if (exp_main.size() == 0 || exp_alt.size() == 0) begin
        check("sb_empty", 32'd0, 32'd1);
      end else begin
        em = exp_main.pop_front();
        ea = exp_alt.pop_front();
        compare_outputs(em, ea);
        for (int i = 0; i < stall; i++) begin
          a = 16'($urandom); b = 16'($urandom); in_valid = 1'($urandom);
          @(posedge clk); #1;
          check("stall_result",   {16'h0, result},    {16'h0, em[15:0]});
          check("stall_overflow", {31'h0, overflow},  {31'h0, em[16]});
          check("stall_valid",    {31'h0, out_valid}, 32'd1);
          check("stall_ready",    {31'h0, in_ready},  32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("back_idle", {30'h0, in_ready, out_valid}, 32'd2);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    #3;
    check("rst_state", {14'h0, in_ready, out_valid, result}, {14'h0, 1'b1, 1'b0, 16'h0});
    check("rst_ovf",   {31'h0, overflow}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    do_op(16'h0600, 16'h0800, 0);
    do_op(16'hFA00, 16'h0800, 0);
    do_op(16'h4000, 16'h1000, 0);
    do_op(16'h8000, 16'h0400, 0);
    do_op(16'h8000, 16'hFC00, 0);
    do_op(16'h0001, 16'h0200, 0);
    do_op(16'hFFFF, 16'h0200, 0);
    do_op(16'h0000, 16'hFC00, 0);
    do_op(16'hC000, 16'hC000, 5);
    for (int k = 0; k < 6; k++) do_op(16'($urandom), 16'($urandom), k % 2);

    // Reset mid-CALC: the pending result must be discarded.
    a = 16'h0600; b = 16'h0800; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_main.push_back(model(16'h0600, 16'h0800, 1, 1));
    exp_alt.push_back(model(16'h0600, 16'h0800, 0, 0));
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_main.delete();
    exp_alt.delete();
    #1;
    check("midrst_state", {14'h0, in_ready, out_valid, result}, {14'h0, 1'b1, 1'b0, 16'h0});
    check("midrst_ovf",   {31'h0, overflow}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    check("inrst_valid",  {31'h0, out_valid}, 32'd0);
    rst_n = 1'b1;
    do_op(16'h0400, 16'h0400, 0);

    check("sb_drained", 32'(exp_main.size() + exp_alt.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
